// File: rtl/fu_wb_scoreboard.sv
// Writeback scoreboard between ID issue and the FU bank: slot[j] holds the op that
// writes the regfile j cycles from now; hazards for the ID instruction are derived from it.
module fu_wb_scoreboard #(
  parameter int                       NUM_FU    = 5,
  parameter int                       FU_ID_W   = 3,
  parameter int                       DEPTH     = 32,
  parameter int                       LAT_W     = 5,
  parameter logic [NUM_FU*LAT_W-1:0]  LAT_VEC   = {5'd2, 5'd2, 5'd24, 5'd7, 5'd1},
  parameter logic [NUM_FU-1:0]        PIPE_MASK = 5'b00101,
  parameter int                       CNT_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [FU_ID_W-1:0] issue_fu,
  input  logic [4:0]         issue_rd,
  input  logic               issue_rd_used,
  input  logic [4:0]         issue_rs1,
  input  logic [4:0]         issue_rs2,
  input  logic               issue_rs1_used,
  input  logic               issue_rs2_used,
  input  logic               kill_valid,
  input  logic [NUM_FU-1:0]  kill_mask,
  output logic               issue_ready,
  output logic               stall_struct,
  output logic               stall_wb,
  output logic               stall_waw,
  output logic               stall_raw,
  output logic               wb_valid,
  output logic [FU_ID_W-1:0] wb_fu,
  output logic [4:0]         wb_rd,
  output logic [NUM_FU-1:0]  fu_busy,
  output logic [CNT_W-1:0]   inflight_cnt
);

  typedef struct packed {
    logic               valid;
    logic [FU_ID_W-1:0] fu;
    logic [4:0]         rd;
    logic               rd_used;
  } slot_t;

  slot_t [DEPTH-1:0] slot_q, slot_d;
  slot_t             new_slot;
  logic [DEPTH-1:1]  killed;
  logic              fu_ok, pipe, rd_used_eff, fire;
  logic              same_fu_hit, wb_hit, waw_hit, raw_hit;
  logic [LAT_W-1:0]  lat;

  // Decode the ID instruction's FU into latency / pipelining.
  always_comb begin
    fu_ok = 1'b0;
    lat   = '0;
    pipe  = 1'b0;
    for (int k = 1; k <= NUM_FU; k++) begin
      if (issue_fu == FU_ID_W'(k)) begin
        fu_ok = 1'b1;
        lat   = LAT_VEC[(k-1)*LAT_W +: LAT_W];
        pipe  = PIPE_MASK[k-1];
      end
    end
    rd_used_eff = issue_rd_used && (issue_rd != 5'd0);
    new_slot    = '{valid: 1'b1, fu: issue_fu, rd: issue_rd, rd_used: rd_used_eff};
  end

  // Slots only record rd_used for rd != 0, so x0 sources can never match.
  always_comb begin
    fu_busy      = '0;
    inflight_cnt = '0;
    same_fu_hit  = 1'b0;
    wb_hit       = 1'b0;
    waw_hit      = 1'b0;
    raw_hit      = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (slot_q[j].valid) begin
        inflight_cnt = inflight_cnt + CNT_W'(1);
        for (int k = 1; k <= NUM_FU; k++)
          if (slot_q[j].fu == FU_ID_W'(k)) fu_busy[k-1] = 1'b1;
        // A latency-1 op lands in slot 0 just as its occupant retires.
        if (slot_q[j].fu == issue_fu && (j > 0 || lat != LAT_W'(1))) same_fu_hit = 1'b1;
        if (j == int'(lat)) wb_hit = 1'b1;
        if (slot_q[j].rd_used && j >= int'(lat) && slot_q[j].rd == issue_rd) waw_hit = 1'b1;
        if (slot_q[j].rd_used && j > 0 &&
            ((issue_rs1_used && issue_rs1 == slot_q[j].rd) ||
             (issue_rs2_used && issue_rs2 == slot_q[j].rd)))
          raw_hit = 1'b1;
      end
    end
  end

  assign stall_struct = fu_ok && !pipe && same_fu_hit;
  assign stall_wb     = fu_ok && wb_hit;
  assign stall_waw    = fu_ok && rd_used_eff && waw_hit;
  assign stall_raw    = fu_ok && raw_hit;
  assign issue_ready  = !(stall_struct || stall_wb || stall_waw || stall_raw || kill_valid);
  assign fire         = issue_valid && issue_ready && fu_ok;

  // Slot 0 always retires; kill only hits ops still in flight behind it.
  always_comb begin
    killed = '0;
    for (int j = 1; j < DEPTH; j++)
      for (int k = 1; k <= NUM_FU; k++)
        if (kill_valid && kill_mask[k-1] && slot_q[j].fu == FU_ID_W'(k)) killed[j] = 1'b1;
  end

  always_comb begin
    slot_d = '0;
    for (int j = 0; j < DEPTH-1; j++)
      slot_d[j] = killed[j+1] ? slot_t'('0) : slot_q[j+1];
    if (fire)
      for (int j = 0; j < DEPTH; j++)
        if (j == int'(lat) - 1) slot_d[j] = new_slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign wb_valid = slot_q[0].valid;
  assign wb_fu    = slot_q[0].fu;
  assign wb_rd    = slot_q[0].rd;

endmodule

// File: tb/tb_fu_wb_scoreboard.sv
// Bench for fu_wb_scoreboard: directed scenarios plus random traffic, checked every
// cycle against a list-of-ops model with absolute writeback times.
module tb_fu_wb_scoreboard;
  localparam int NUM_FU = 5, FU_ID_W = 3, DEPTH = 32, LAT_W = 5, CNT_W = 6;
  localparam logic [NUM_FU*LAT_W-1:0] LAT_VEC = {5'd2, 5'd2, 5'd24, 5'd7, 5'd1};
  // ALU and MUL pipelined; DIV, MEM, JUMP accept one op at a time.
  localparam logic [NUM_FU-1:0] PIPE_MASK = 5'b00011;

  logic clk = 1'b0, rst = 1'b0;
  logic issue_valid = 1'b0, issue_rd_used = 1'b0, issue_rs1_used = 1'b0, issue_rs2_used = 1'b0;
  logic [FU_ID_W-1:0] issue_fu = '0;
  logic [4:0] issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic kill_valid = 1'b0;
  logic [NUM_FU-1:0] kill_mask = '0;
  logic issue_ready, stall_struct, stall_wb, stall_waw, stall_raw, wb_valid;
  logic [FU_ID_W-1:0] wb_fu;
  logic [4:0] wb_rd;
  logic [NUM_FU-1:0] fu_busy;
  logic [CNT_W-1:0] inflight_cnt;

  fu_wb_scoreboard #(.NUM_FU(NUM_FU), .FU_ID_W(FU_ID_W), .DEPTH(DEPTH), .LAT_W(LAT_W),
                     .LAT_VEC(LAT_VEC), .PIPE_MASK(PIPE_MASK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_rd(issue_rd),
    .issue_rd_used(issue_rd_used), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .kill_valid(kill_valid), .kill_mask(kill_mask), .issue_ready(issue_ready),
    .stall_struct(stall_struct), .stall_wb(stall_wb), .stall_waw(stall_waw),
    .stall_raw(stall_raw), .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_rd(wb_rd),
    .fu_busy(fu_busy), .inflight_cnt(inflight_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: each in-flight op with the cycle number its result is written.
  typedef struct {int fu; int rd; bit rdu; int due;} op_t;
  op_t ops[$];
  int  cyc = 0;
  int  lat_tab [1:NUM_FU] = '{1, 7, 24, 2, 2};
  bit  pipe_tab[1:NUM_FU] = '{1, 1, 0, 0, 0};

  always @(negedge clk) begin
    int fu, L, r, e_busy, wi;
    bit ok, rdu, es, ew, ewaw, eraw, erdy;
    if (rst) ops.delete();
    fu  = int'(issue_fu);
    ok  = (fu >= 1 && fu <= NUM_FU);
    L   = ok ? lat_tab[fu] : 0;
    rdu = issue_rd_used && issue_rd != 5'd0;
    es = 0; ew = 0; ewaw = 0; eraw = 0; e_busy = 0; wi = -1;
    foreach (ops[i]) begin
      r = ops[i].due - cyc;
      e_busy |= 1 << (ops[i].fu - 1);
      if (r == 0) wi = i;
      if (ok) begin
        if (!pipe_tab[fu] && ops[i].fu == fu && r >= (L == 1 ? 1 : 0)) es = 1;
        if (r == L) ew = 1;
        if (rdu && ops[i].rdu && ops[i].rd == int'(issue_rd) && r >= L) ewaw = 1;
        if (r >= 1 && ops[i].rdu &&
            ((issue_rs1_used && int'(issue_rs1) == ops[i].rd) ||
             (issue_rs2_used && int'(issue_rs2) == ops[i].rd))) eraw = 1;
      end
    end
    erdy = !(es || ew || ewaw || eraw || kill_valid);
    chk("stall_struct", stall_struct, es);
    chk("stall_wb", stall_wb, ew);
    chk("stall_waw", stall_waw, ewaw);
    chk("stall_raw", stall_raw, eraw);
    chk("issue_ready", issue_ready, erdy);
    chk("fu_busy", int'(fu_busy), e_busy);
    chk("inflight_cnt", int'(inflight_cnt), ops.size());
    // Writeback monitor: pop the op due this cycle.
    chk("wb_valid", wb_valid, wi >= 0);
    if (wb_valid && wi >= 0) begin
      chk("wb_fu", int'(wb_fu), ops[wi].fu);
      chk("wb_rd", int'(wb_rd), ops[wi].rd);
    end
    if (wi >= 0) ops.delete(wi);
    if (kill_valid && !rst)
      for (int i = ops.size() - 1; i >= 0; i--)
        if (ops[i].due > cyc && kill_mask[ops[i].fu - 1]) ops.delete(i);
    if (!rst && issue_valid && erdy && ok)
      ops.push_back('{fu, int'(issue_rd), rdu, cyc + L});
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    issue_valid = 1'b0; kill_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue_wait(input int fu, input int rd, input int rs1, input bit rs1u,
                            output int waited, output logic [3:0] first);
    issue_valid = 1'b1; issue_fu = FU_ID_W'(fu); issue_rd = 5'(rd); issue_rd_used = 1'b1;
    issue_rs1 = 5'(rs1); issue_rs1_used = rs1u; issue_rs2 = '0; issue_rs2_used = 1'b0;
    waited = 0;
    @(negedge clk);
    first = {stall_struct, stall_wb, stall_waw, stall_raw};
    while (!issue_ready && waited < 100) begin waited++; @(negedge clk); end
    chk("issue_accept", issue_ready, 1);
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nwb;
    logic [3:0] f;
    int seen[$];
    #1 rst = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_cnt", int'(inflight_cnt), 0);
    chk("rst_ready", issue_ready, 1);
    step(); rst = 1'b0;
    step();

    // ADD: one-cycle latency.
    issue_wait(1, 5, 0, 0, w, f);
    chk("add_wait", w, 0);
    @(negedge clk);
    chk("add_wb_valid", wb_valid, 1); chk("add_wb_fu", int'(wb_fu), 1); chk("add_wb_rd", int'(wb_rd), 5);
    step(); @(negedge clk);
    chk("add_cnt_zero", int'(inflight_cnt), 0);
    drain(2);

    // Back-to-back DIV: second one waits until the first has left slot 0.
    issue_wait(3, 6, 0, 0, w, f);
    issue_wait(3, 11, 0, 0, w, f);
    chk("div_struct_first", int'(f), 4'b1000);
    chk("div_struct_wait", w, 24);
    drain(30);

    // Pipelined MUL x3, results on consecutive cycles.
    issue_wait(2, 7, 0, 0, w, f); chk("mul0_wait", w, 0);
    issue_wait(2, 8, 0, 0, w, f); chk("mul1_wait", w, 0);
    issue_wait(2, 9, 0, 0, w, f); chk("mul2_wait", w, 0);
    repeat (12) begin @(negedge clk); if (wb_valid) seen.push_back(int'(wb_rd)); end
    chk("mul_wb_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("mul_wb_rd0", seen[0], 7); chk("mul_wb_rd1", seen[1], 8); chk("mul_wb_rd2", seen[2], 9);
    end
    drain(3);

    // WAW then RAW against an in-flight MUL.
    issue_wait(2, 10, 0, 0, w, f);
    issue_wait(1, 10, 0, 0, w, f);
    chk("waw_first", int'(f), 4'b0010); chk("waw_wait", w, 6);
    drain(10);
    issue_wait(2, 10, 0, 0, w, f);
    issue_wait(1, 12, 10, 1, w, f);
    chk("raw_first", int'(f), 4'b0001); chk("raw_wait", w, 6);
    drain(10);

    // Writeback-port collision: ALU after MEM stalls, JUMP after MEM does not.
    issue_wait(4, 13, 0, 0, w, f);
    issue_wait(1, 14, 0, 0, w, f);
    chk("wbport_first", int'(f), 4'b0100); chk("wbport_wait", w, 1);
    drain(5);
    issue_wait(4, 15, 0, 0, w, f);
    issue_wait(5, 16, 0, 0, w, f);
    chk("jump_wait", w, 0);
    drain(5);

    // Kill an in-flight DIV.
    issue_wait(3, 17, 0, 0, w, f);
    kill_valid = 1'b1; kill_mask = 5'b00100;
    @(negedge clk);
    chk("kill_ready", issue_ready, 0);
    step(); kill_valid = 1'b0; kill_mask = '0;
    @(negedge clk);
    chk("kill_busy_div", int'(fu_busy[2]), 0);
    nwb = 0;
    repeat (30) begin @(negedge clk); if (wb_valid) nwb++; end
    chk("kill_no_wb", nwb, 0);
    step();

    // Reset in the middle of traffic clears immediately.
    issue_wait(2, 18, 0, 0, w, f);
    issue_wait(3, 19, 0, 0, w, f);
    rst = 1'b1;
    #1 chk("rst_async_cnt", int'(inflight_cnt), 0);
    chk("rst_async_busy", int'(fu_busy), 0);
    step(); rst = 1'b0;
    step();

    // Random traffic, including invalid FU ids, x0 registers and kills.
    repeat (2000) begin
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_fu       = FU_ID_W'($urandom_range(0, 7));
      issue_rd       = 5'($urandom_range(0, 7));
      issue_rd_used  = 1'($urandom_range(0, 1));
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_rs1_used = 1'($urandom_range(0, 1));
      issue_rs2_used = 1'($urandom_range(0, 1));
      kill_valid     = ($urandom_range(0, 19) == 0);
      kill_mask      = NUM_FU'($urandom_range(0, 31));
      step();
    end
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
